// File: rtl/seg_pkg.sv
// Shared constants, glyph table and BCD helpers for the multiplexed 7-segment display driver.
// Latency: none (package only).
// Backpressure: none (package only).
package seg_pkg;

   localparam int          DIGITS      = 6;
   localparam int          BCD_W       = 24;
   localparam int          BIN_W       = 20;
   localparam logic [19:0] SAT_MAX     = 20'd999_999;

   // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}; dp is off in every constant.
   localparam logic [7:0]  GLYPH_0     = 8'hC0;
   localparam logic [7:0]  GLYPH_1     = 8'hF9;
   localparam logic [7:0]  GLYPH_2     = 8'hA4;
   localparam logic [7:0]  GLYPH_3     = 8'hB0;
   localparam logic [7:0]  GLYPH_4     = 8'h99;
   localparam logic [7:0]  GLYPH_5     = 8'h92;
   localparam logic [7:0]  GLYPH_6     = 8'h82;
   localparam logic [7:0]  GLYPH_7     = 8'hF8;
   localparam logic [7:0]  GLYPH_8     = 8'h80;
   localparam logic [7:0]  GLYPH_9     = 8'h90;
   localparam logic [7:0]  GLYPH_BLANK = 8'hFF;
   localparam logic [7:0]  GLYPH_MINUS = 8'hBF;

   typedef enum logic {
      CONV_IDLE  = 1'b0,
      CONV_SHIFT = 1'b1
   } conv_state_t;

   // Maps one BCD digit to its active-low glyph; non-decimal codes go dark.
   function automatic logic [7:0] glyph(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'd0:    g = GLYPH_0;
         4'd1:    g = GLYPH_1;
         4'd2:    g = GLYPH_2;
         4'd3:    g = GLYPH_3;
         4'd4:    g = GLYPH_4;
         4'd5:    g = GLYPH_5;
         4'd6:    g = GLYPH_6;
         4'd7:    g = GLYPH_7;
         4'd8:    g = GLYPH_8;
         4'd9:    g = GLYPH_9;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the next left shift.
   function automatic logic [23:0] bcd_add3(input logic [23:0] v);
      logic [23:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter, 20-bit binary to 6 BCD digits.
// Latency: 21 clks from start (1 load + 20 shift/add-3), then a 1-clk done pulse with bcd valid.
// Backpressure: start is ignored while busy; bcd holds until the next conversion starts.
module bin_to_bcd
   import seg_pkg::*;
(
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        start,
   input  logic [19:0] bin,
   output logic        busy,
   output logic        done,
   output logic [23:0] bcd
);

   conv_state_t              state_q, state_d;
   logic [BIN_W-1:0]         bin_q, bin_d;
   logic [BCD_W-1:0]         bcd_q, bcd_d;
   logic [4:0]               shift_cnt_q, shift_cnt_d;
   logic                     done_q, done_d;
   logic [BCD_W+BIN_W-1:0]   shift_v;

   // Next-state: load on start, then 20 adjust-and-shift steps, pulsing done on the last one.
   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      shift_cnt_d = shift_cnt_q;
      done_d      = 1'b0;
      shift_v     = {bcd_add3(bcd_q), bin_q};
      case (state_q)
         CONV_IDLE: begin
            if (start) begin
               state_d     = CONV_SHIFT;
               bin_d       = bin;
               bcd_d       = '0;
               shift_cnt_d = 5'(BIN_W);
            end
         end
         CONV_SHIFT: begin
            {bcd_d, bin_d} = {shift_v[BCD_W+BIN_W-2:0], 1'b0};
            shift_cnt_d    = shift_cnt_q - 5'd1;
            if (shift_cnt_q == 5'd1) begin
               state_d = CONV_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = CONV_IDLE;
      endcase
   end

   // State registers; reset aborts any conversion in flight.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= CONV_IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         shift_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         shift_cnt_q <= shift_cnt_d;
         done_q      <= done_d;
      end
   end

   assign busy = (state_q == CONV_SHIFT);
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: rtl/seg_dynamic_scan.sv
// Six-digit common-anode 7-segment scan driver with decimal conversion, blanking, dp and minus sign.
// Latency: sel/seg registered 1 clk after idx; new data shows from the frame after the idx=5 sample.
// Backpressure: none; seg_en=0 darkens the display and keeps bcd_disp tracking data continuously.
module seg_dynamic_scan
   import seg_pkg::*;
#(
   parameter int CNT_MAX = 49_999
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [19:0] data,
   input  logic [5:0]  point,
   input  logic        sign,
   input  logic        seg_en,
   output logic [5:0]  sel,
   output logic [7:0]  seg
);

   localparam int            CW       = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [BCD_W-1:0] bcd_next_q, bcd_next_d;
   logic [BCD_W-1:0] bcd_disp_q, bcd_disp_d;
   logic [5:0]       sel_q, sel_d;
   logic [7:0]       seg_q, seg_d;

   logic             conv_start;
   logic             conv_busy;
   logic             conv_done;
   logic [BCD_W-1:0] conv_bcd;
   logic [BIN_W-1:0] sat_bin;
   logic             frame_wrap;
   logic [2:0]       top_nz;
   logic [2:0]       top_pt;
   logic [2:0]       top;
   logic [7:0]       dig_glyph;

   assign sat_bin    = (data > SAT_MAX) ? SAT_MAX : data;
   assign frame_wrap = (cnt_q == CNT_LAST) && (idx_q == 3'd5);

   // While scanning, sample once per frame at the start of digit 5; while dark, convert back-to-back.
   assign conv_start = seg_en ? ((idx_q == 3'd5) && (cnt_q == '0)) : !conv_busy;

   bin_to_bcd u_bin_to_bcd (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .start     (conv_start),
      .bin       (sat_bin),
      .busy      (conv_busy),
      .done      (conv_done),
      .bcd       (conv_bcd)
   );

   // Dwell counter and digit index; both parked at 0 while the display is dark.
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (!seg_en) begin
         cnt_d = '0;
         idx_d = 3'd0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Double buffer: done fills bcd_next; bcd_disp swaps only on frame wrap so a frame is never torn.
   always_comb begin
      bcd_next_d = conv_done ? conv_bcd : bcd_next_q;
      bcd_disp_d = bcd_disp_q;
      if (!seg_en) begin
         if (conv_done) begin
            bcd_disp_d = conv_bcd;
         end
      end else if (frame_wrap) begin
         bcd_disp_d = bcd_next_q;
      end
   end

   // Significance: highest nonzero digit or highest requested dp, whichever is further left.
   always_comb begin
      top_nz = 3'd0;
      top_pt = 3'd0;
      for (int i = 1; i < DIGITS; i++) begin
         if (bcd_disp_q[4*i +: 4] != 4'd0) begin
            top_nz = 3'(i);
         end
         if (point[i]) begin
            top_pt = 3'(i);
         end
      end
      top = (top_pt > top_nz) ? top_pt : top_nz;
   end

   // Output decode for the digit under idx: shown digit, minus sign just left of top, or blank.
   always_comb begin
      dig_glyph = glyph(bcd_disp_q[4*idx_q +: 4]);
      sel_d     = 6'b000000;
      seg_d     = GLYPH_BLANK;
      if (seg_en) begin
         sel_d = 6'b000001 << idx_q;
         if (idx_q <= top) begin
            seg_d = {~point[idx_q], dig_glyph[6:0]};
         end else if (sign && (top < 3'd5) && (idx_q == top + 3'd1)) begin
            seg_d = GLYPH_MINUS;
         end
      end
   end

   // All scan state and output registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q      <= '0;
         idx_q      <= 3'd0;
         bcd_next_q <= '0;
         bcd_disp_q <= '0;
         sel_q      <= 6'b000000;
         seg_q      <= GLYPH_BLANK;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         bcd_next_q <= bcd_next_d;
         bcd_disp_q <= bcd_disp_d;
         sel_q      <= sel_d;
         seg_q      <= seg_d;
      end
   end

   assign sel = sel_q;
   assign seg = seg_q;

endmodule
